// File: rtl/fade_sequencer.sv
// Three-channel level fader: on enable, ramps each level toward its latched
// target by at most STEP every PRESCALE clocks, then pulses done.
module fade_sequencer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1024,
    parameter int STEP     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] target0,
    input  logic [WIDTH-1:0] target1,
    input  logic [WIDTH-1:0] target2,
    output logic [WIDTH-1:0] level0,
    output logic [WIDTH-1:0] level1,
    output logic [WIDTH-1:0] level2,
    output logic             busy,
    output logic             done
);

    localparam int               PW      = $clog2(PRESCALE);
    localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH:0]   STEP_W  = (WIDTH + 1)'(STEP);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] level_q [3];
    logic [WIDTH-1:0] level_d [3];
    logic [WIDTH-1:0] tgt_q   [3];
    logic [WIDTH-1:0] tgt_d   [3];
    logic             done_q, done_d;
    logic             mismatch;
    logic             tick;
    logic             settled;

    // One extra bit keeps the distance and the stepped value from wrapping
    // past either end of the level range.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] tgt);
        logic [WIDTH:0] cur_w;
        logic [WIDTH:0] tgt_w;
        logic [WIDTH:0] diff;
        cur_w = {1'b0, cur};
        tgt_w = {1'b0, tgt};
        diff  = (tgt_w >= cur_w) ? (tgt_w - cur_w) : (cur_w - tgt_w);
        if (diff <= STEP_W)
            return tgt;
        else if (tgt_w > cur_w)
            return WIDTH'(cur_w + STEP_W);
        else
            return WIDTH'(cur_w - STEP_W);
    endfunction

    assign mismatch = (target0 != level_q[0]) || (target1 != level_q[1]) ||
                      (target2 != level_q[2]);
    assign tick     = (pre_q == PRE_MAX) && enable;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        settled = 1'b1;
        for (int i = 0; i < 3; i++) begin
            level_d[i] = level_q[i];
            tgt_d[i]   = tgt_q[i];
        end

        unique case (state_q)
            IDLE: begin
                if (enable && mismatch) begin
                    state_d  = RAMP;
                    pre_d    = '0;
                    tgt_d[0] = target0;
                    tgt_d[1] = target1;
                    tgt_d[2] = target2;
                end
            end
            RAMP: begin
                if (tick) begin
                    pre_d = '0;
                    for (int i = 0; i < 3; i++) begin
                        level_d[i] = step_toward(level_q[i], tgt_q[i]);
                        settled    = settled && (level_d[i] == tgt_q[i]);
                    end
                    if (settled) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (enable) begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pre_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                level_q[i] <= '0;
                tgt_q[i]   <= '0;
            end
        end else begin
            // NOTE: state uses non-blocking assignment so every register
            // samples the pre-edge values computed by the comb block.
            state_q <= state_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
            for (int i = 0; i < 3; i++) begin
                level_q[i] <= level_d[i];
                tgt_q[i]   <= tgt_d[i];
            end
        end
    end

    assign level0 = level_q[0];
    assign level1 = level_q[1];
    assign level2 = level_q[2];
    assign busy   = (state_q == RAMP);
    assign done   = done_q;

endmodule

// File: tb/tb_fade_sequencer.sv
// Bench for fade_sequencer: expected output-change events are queued when a
// ramp is launched and matched against every observed change of the outputs.
module tb_fade_sequencer;

    localparam int PS = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       a_en, b_en;
    logic [7:0] a_t0, a_t1, a_t2, b_t0, b_t1, b_t2;
    logic [7:0] a_l0, a_l1, a_l2, b_l0, b_l1, b_l2;
    logic       a_busy, a_done, b_busy, b_done;

    fade_sequencer #(.WIDTH(8), .PRESCALE(PS), .STEP(1)) dut_a (
        .clk(clk), .reset(reset), .enable(a_en),
        .target0(a_t0), .target1(a_t1), .target2(a_t2),
        .level0(a_l0), .level1(a_l1), .level2(a_l2),
        .busy(a_busy), .done(a_done)
    );

    fade_sequencer #(.WIDTH(8), .PRESCALE(PS), .STEP(16)) dut_b (
        .clk(clk), .reset(reset), .enable(b_en),
        .target0(b_t0), .target1(b_t1), .target2(b_t2),
        .level0(b_l0), .level1(b_l1), .level2(b_l2),
        .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int at_edge;
        int l0, l1, l2;
        bit busy;
        bit done;
    } ev_t;

    ev_t        q_a[$];
    ev_t        q_b[$];
    logic [25:0] prev_snap [2];

    function automatic logic [25:0] snap_of(input int sel);
        if (sel == 0) return {a_l0, a_l1, a_l2, a_busy, a_done};
        else          return {b_l0, b_l1, b_l2, b_busy, b_done};
    endfunction

    task automatic push_ev(input int sel, input ev_t e);
        if (sel == 0) q_a.push_back(e);
        else          q_b.push_back(e);
    endtask

    // Independent ramp model: after k ticks a channel has moved
    // min(k*step, |t-s|) toward its target; ramp length is the slowest channel.
    task automatic plan_ramp(input int sel, input int entry,
                             input int s0, input int s1, input int s2,
                             input int t0, input int t1, input int t2,
                             input int step, input bit push_entry, input bit restart,
                             input int hold_after, input int hold_len,
                             input int stop_after, output int final_edge);
        int  s[3];
        int  t[3];
        int  lv[3];
        int  n;
        ev_t e;
        s[0] = s0; s[1] = s1; s[2] = s2;
        t[0] = t0; t[1] = t1; t[2] = t2;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            int mag;
            mag = (t[c] > s[c]) ? t[c] - s[c] : s[c] - t[c];
            if ((mag + step - 1) / step > n) n = (mag + step - 1) / step;
        end
        if (push_entry) begin
            e = '{at_edge: entry, l0: s0, l1: s1, l2: s2, busy: 1'b1, done: 1'b0};
            push_ev(sel, e);
        end
        for (int k = 1; k <= n; k++) begin
            if (stop_after > 0 && k > stop_after) break;
            for (int c = 0; c < 3; c++) begin
                int d, mag, mv;
                d   = t[c] - s[c];
                mag = (d < 0) ? -d : d;
                mv  = (k * step < mag) ? k * step : mag;
                lv[c] = (d < 0) ? s[c] - mv : s[c] + mv;
            end
            e.at_edge = entry + k * PS + ((k > hold_after) ? hold_len : 0);
            e.l0 = lv[0]; e.l1 = lv[1]; e.l2 = lv[2];
            e.busy = (k < n);
            e.done = (k == n);
            push_ev(sel, e);
        end
        final_edge = entry + n * PS + ((n > hold_after) ? hold_len : 0);
        if (stop_after == 0 || stop_after >= n) begin
            e = '{at_edge: final_edge + 1, l0: t0, l1: t1, l2: t2, busy: restart, done: 1'b0};
            push_ev(sel, e);
        end
    endtask

    task automatic monitor_dut(input int sel);
        logic [25:0] snap;
        logic [25:0] exp_snap;
        ev_t         e;
        bit          have;
        snap = snap_of(sel);
        if (snap === prev_snap[sel]) return;
        prev_snap[sel] = snap;
        vectors++;
        have = 1'b0;
        if (sel == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
        if (sel == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
        if (!have) begin
            miscompares++;
            $display("FAIL unexpected_change dut%0d: got edge %0d l=%0d/%0d/%0d busy=%0b done=%0b, required no change",
                     sel, cyc, snap[25:18], snap[17:10], snap[9:2], snap[1], snap[0]);
        end else begin
            exp_snap = {8'(e.l0), 8'(e.l1), 8'(e.l2), e.busy, e.done};
            if (snap !== exp_snap || cyc != e.at_edge) begin
                miscompares++;
                $display("FAIL event dut%0d: got edge %0d l=%0d/%0d/%0d busy=%0b done=%0b, required edge %0d l=%0d/%0d/%0d busy=%0b done=%0b",
                         sel, cyc, snap[25:18], snap[17:10], snap[9:2], snap[1], snap[0],
                         e.at_edge, e.l0, e.l1, e.l2, e.busy, e.done);
            end
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        if (!reset) begin
            monitor_dut(0);
            monitor_dut(1);
        end
    endtask

    task automatic run_until(input int k);
        while (cyc < k) run_cycle();
    endtask

    task automatic check_empty(input string name);
        vectors++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            miscompares++;
            $display("FAIL %s: got %0d/%0d expected events never observed, required 0/0",
                     name, q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        prev_snap[0] = '0;
        prev_snap[1] = '0;
    endtask

    task automatic test_reset();
        a_en = 1'b0; b_en = 1'b0;
        {a_t0, a_t1, a_t2} = '0;
        {b_t0, b_t1, b_t2} = '0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if (snap_of(s) !== 26'd0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got %h, required 0", s, snap_of(s));
            end
        end
        reset = 1'b0;
        prev_snap[0] = '0;
        prev_snap[1] = '0;
        // Target changes with enable low must not start a ramp.
        a_t0 = 8'd5; a_t1 = 8'd5; a_t2 = 8'd5;
        repeat (8) run_cycle();
        vectors++;
        if (a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold: got busy=%0b, required 0", a_busy);
        end
        check_empty("idle_hold_events");
    endtask

    task automatic test_single_ramp();
        int entry, fin;
        a_t0 = 8'd3; a_t1 = 8'd0; a_t2 = 8'd0;
        a_en = 1'b1;
        entry = cyc + 1;
        plan_ramp(0, entry, 0, 0, 0, 3, 0, 0, 1, 1'b1, 1'b0, 1000, 0, 0, fin);
        run_until(fin + 4);
        check_empty("single_ramp");
    endtask

    task automatic test_independent();
        int entry, fin;
        pulse_reset();
        a_t0 = 8'd2; a_t1 = 8'd5; a_t2 = 8'd0;
        a_en = 1'b1;
        entry = cyc + 1;
        plan_ramp(0, entry, 0, 0, 0, 2, 5, 0, 1, 1'b1, 1'b0, 1000, 0, 0, fin);
        run_until(fin + 4);
        check_empty("independent");
    endtask

    task automatic test_enable_pause();
        int entry, fin;
        a_t0 = 8'd0; a_t1 = 8'd9; a_t2 = 8'd3;
        entry = cyc + 1;
        plan_ramp(0, entry, 2, 5, 0, 0, 9, 3, 1, 1'b1, 1'b0, 2, 10, 0, fin);
        run_until(entry + 2 * PS);
        a_en = 1'b0;
        repeat (5) run_cycle();
        vectors++;
        if ({a_busy, a_done} !== 2'b10) begin
            miscompares++;
            $display("FAIL pause_busy: got busy=%0b done=%0b, required busy=1 done=0", a_busy, a_done);
        end
        repeat (5) run_cycle();
        a_en = 1'b1;
        run_until(fin + 4);
        check_empty("enable_pause");
    endtask

    task automatic test_back_to_back();
        int entry, fin1, fin2;
        a_t0 = 8'd3; a_t1 = 8'd9; a_t2 = 8'd3;
        entry = cyc + 1;
        plan_ramp(0, entry, 0, 9, 3, 3, 9, 3, 1, 1'b1, 1'b1, 1000, 0, 0, fin1);
        plan_ramp(0, fin1 + 1, 3, 9, 3, 7, 9, 3, 1, 1'b0, 1'b0, 1000, 0, 0, fin2);
        run_until(entry + PS);
        a_t0 = 8'd7;
        run_until(fin2 + 4);
        check_empty("back_to_back");
    endtask

    task automatic test_big_step();
        int entry, fin;
        b_t0 = 8'd250; b_t1 = 8'd0; b_t2 = 8'd0;
        b_en = 1'b1;
        entry = cyc + 1;
        plan_ramp(1, entry, 0, 0, 0, 250, 0, 0, 16, 1'b1, 1'b0, 1000, 0, 0, fin);
        run_until(fin + 3);
        b_t0 = 8'd0;
        entry = cyc + 1;
        plan_ramp(1, entry, 250, 0, 0, 0, 0, 0, 16, 1'b1, 1'b0, 1000, 0, 0, fin);
        run_until(fin + 4);
        check_empty("big_step");
    endtask

    task automatic test_async_reset();
        int entry, fin;
        a_t0 = 8'd0; a_t1 = 8'd0; a_t2 = 8'd0;
        entry = cyc + 1;
        plan_ramp(0, entry, 7, 9, 3, 0, 0, 0, 1, 1'b1, 1'b0, 1000, 0, 2, fin);
        run_until(entry + 2 * PS + 1);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (snap_of(0) !== 26'd0) begin
            miscompares++;
            $display("FAIL async_reset: got l=%0d/%0d/%0d busy=%0b done=%0b, required all 0",
                     a_l0, a_l1, a_l2, a_busy, a_done);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        prev_snap[0] = '0;
        prev_snap[1] = '0;
        check_empty("async_reset_abort");
        repeat (12) run_cycle();
        check_empty("async_reset_quiet");
    endtask

    initial begin
        test_reset();
        test_single_ramp();
        test_independent();
        test_enable_pause();
        test_back_to_back();
        test_big_step();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fade_sequencer.md
FADE_SEQUENCER -- requirements
Module: fade_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: bit width of every level and target.
REQ-002 Parameter PRESCALE, default 1024: clocks per ramp tick; legal range 2..65535.
REQ-003 Parameter STEP, default 1: maximum level change per tick per channel; legal range 1..2^WIDTH-1.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  high = ramping allowed; low = freeze levels and prescaler.
REQ-007 target0, target1, target2  input  WIDTH each  requested level per channel (from encoder values).
REQ-008 level0, level1, level2  output  WIDTH each  registered level driven to the PWM level inputs.
REQ-009 busy  output  1  high while state is RAMP.
REQ-010 done  output  1  registered one-cycle pulse on ramp completion.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and RAMP; busy = (state == RAMP), decoded from the state register.
REQ-012 IDLE -> RAMP SHALL occur on the edge where enable=1 and any targetN != levelN; on that edge targets are latched into internal tgtN registers and the prescaler is cleared to 0.
REQ-013 In IDLE, levels, tgtN and prescaler SHALL hold; target changes with enable=0 cause no transition.
REQ-014 In RAMP with enable=1, the prescaler SHALL count 0..PRESCALE-1 and wrap to 0; tick = (prescaler == PRESCALE-1) && enable.
REQ-015 On a tick edge, each channel SHALL update: if |tgtN-levelN| <= STEP then levelN <= tgtN; else levelN moves STEP toward tgtN.
REQ-016 Difference and step arithmetic SHALL use WIDTH+1 bits so no level wraps past 0 or 2^WIDTH-1.
REQ-017 First level update SHALL occur PRESCALE clocks after the IDLE->RAMP edge; subsequent updates every PRESCALE clocks.
REQ-018 Channels SHALL step independently; a channel already at target holds while others ramp.
REQ-019 When, on a tick edge, all three updated levels equal their tgtN, state SHALL go to IDLE on that same edge and done SHALL be 1 for exactly the following cycle.
REQ-020 targetN changes during RAMP SHALL be ignored; on return to IDLE, any remaining mismatch with enable=1 starts a new RAMP on the next edge (done and the new RAMP entry may coincide).
REQ-021 enable=0 in RAMP SHALL freeze the prescaler and levels and keep state RAMP and busy=1; counting resumes from the frozen prescaler value when enable returns.
REQ-022 done SHALL never be asserted in any cycle other than that following a completing tick; busy and done may be high in the same cycle only when REQ-020's immediate restart occurs.

Reset
REQ-023 While reset=1, regardless of clk: state=IDLE, prescaler=0, tgtN=0, levelN=0, busy=0, done=0.
REQ-024 Reset asserted mid-ramp SHALL abort immediately with no done pulse; after release, a new ramp begins only per REQ-012.

Verification
REQ-025 PRESCALE=4, STEP=1, targets (3,0,0), enable=1 after reset: busy rises next edge; level0 = 1,2,3 at 4,8,12 clocks after entry; done pulses once; busy low after the 12th clock.
REQ-026 STEP=16, level0=250, target0=0: level0 steps 234,218,...,10, then 0 on the final tick; never wraps to values above 250.
REQ-027 Targets (2,5,0) from (0,0,0), STEP=1: level0 stops at 2 after tick 2 while level1 continues to 5; single done after tick 5.
REQ-028 enable dropped for 10 clocks mid-ramp: levels and prescaler constant, busy=1, no done; completion delayed by exactly 10 clocks.
REQ-029 target0 changed 3->7 mid-ramp: ramp ends at 3 with done, then busy re-asserts on the same edge and level0 ramps to 7.
REQ-030 reset pulsed (asynchronously, between clock edges) mid-ramp: all levels 0, busy 0 immediately, no done pulse.
